logic_unit_seq: RTL and testbench

//  Parametrised sequential bitwise logic unit; successor to the fixed 32-bit OR array.
//  - Ops: AND, OR, XOR, NOR on WIDTH-bit operands.
//  - Processes SLICE bits per cycle to trade latency for area.
//  - Valid/ready on input and output; sits between decode and writeback in the multi-cycle datapath.

---
 rtl/lu_pkg.sv | 17 +
 rtl/lu_slice.sv | 24 ++
 rtl/logic_unit_seq.sv | 132 +++++++++++++
 tb/tb_logic_unit_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lu_pkg.sv
// rtl/lu_pkg.sv - shared operation and state encodings for the sequential logic unit
package lu_pkg;

  typedef enum logic [1:0] {
    LU_AND = 2'b00,
    LU_OR  = 2'b01,
    LU_XOR = 2'b10,
    LU_NOR = 2'b11
  } lu_op_e;

  typedef enum logic [1:0] {
    LU_IDLE = 2'b00,
    LU_BUSY = 2'b01,
    LU_DONE = 2'b10
  } lu_state_e;

endpackage

// File: rtl/lu_slice.sv
// rtl/lu_slice.sv - combinational SLICE-bit bitwise operation
module lu_slice
  import lu_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  lu_op_e           op,
  output logic [SLICE-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      LU_AND:  y = a & b;
      LU_OR:   y = a | b;
      LU_XOR:  y = a ^ b;
      LU_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_seq.sv
// rtl/logic_unit_seq.sv - sequential WIDTH-bit logic unit, SLICE bits per cycle (optional zero_o via LU_ZERO_FLAG_EN)
module logic_unit_seq
  import lu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] rd_o,
  output logic             busy_o
`ifdef LU_ZERO_FLAG_EN
  ,
  output logic             zero_o
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $error("logic_unit_seq: WIDTH must be a multiple of SLICE");
  end

  lu_state_e        state_q;
  logic [CW-1:0]    cnt_q;
  lu_op_e           op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rd_q;
  logic [WIDTH-1:0] rd_next;
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] y_sl;
  logic             accept;

  // Ready is combinational on out_ready_i so a drained result can be replaced in the same edge.
  assign in_ready_o  = !flush_i && ((state_q == LU_IDLE) ||
                                    ((state_q == LU_DONE) && out_ready_i));
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q == LU_DONE);
  assign busy_o      = (state_q != LU_IDLE);
  assign rd_o        = rd_q;

  always_comb begin
    a_sl    = '0;
    b_sl    = '0;
    rd_next = rd_q;
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt_q == CW'(i)) begin
        a_sl                      = a_q[i*SLICE +: SLICE];
        b_sl                      = b_q[i*SLICE +: SLICE];
        rd_next[i*SLICE +: SLICE] = y_sl;
      end
    end
  end

  lu_slice #(.SLICE(SLICE)) u_slice (
    .a  (a_sl),
    .b  (b_sl),
    .op (op_q),
    .y  (y_sl)
  );

`ifdef LU_ZERO_FLAG_EN
  logic zero_q;
  assign zero_o = zero_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      zero_q <= 1'b0;
    end else if (flush_i || accept) begin
      zero_q <= 1'b0;
    end else if ((state_q == LU_BUSY) && (cnt_q == LAST)) begin
      zero_q <= (rd_next == '0);
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LU_IDLE;
      cnt_q   <= '0;
      op_q    <= LU_AND;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
    end else if (flush_i) begin
      state_q <= LU_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      unique case (state_q)
        LU_IDLE, LU_DONE: begin
          if (accept) begin
            op_q    <= lu_op_e'(op_i);
            a_q     <= rs1_i;
            b_q     <= rs2_i;
            rd_q    <= '0;
            cnt_q   <= '0;
            state_q <= LU_BUSY;
          end else if ((state_q == LU_DONE) && out_ready_i) begin
            state_q <= LU_IDLE;
          end
        end
        LU_BUSY: begin
          rd_q <= rd_next;
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= LU_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= LU_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_seq.sv
// tb/tb_logic_unit_seq.sv - self-checking bench for logic_unit_seq against a transaction-level model
module tb_logic_unit_seq;
  import lu_pkg::*;

  localparam int WIDTH = 32;
  localparam int SLICE = 8;
  localparam int NSL   = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs1;
  logic [WIDTH-1:0] rs2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] rd;
  logic             busy;
`ifdef LU_ZERO_FLAG_EN
  logic             zero;
`endif

  always #5 clk = ~clk;

  logic_unit_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_i        (op),
    .rs1_i       (rs1),
    .rs2_i       (rs2),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .rd_o        (rd),
    .busy_o      (busy)
`ifdef LU_ZERO_FLAG_EN
    ,
    .zero_o      (zero)
`endif
  );

  int  n_vec = 0;
  int  n_err = 0;
  bit  check_en = 1'b0;

  // Model: cycles until the pending result appears, whether one is being offered, and its value.
  int          m_left;
  bit          m_done;
  bit          m_acc;
  logic [31:0] m_res;

  function automatic logic [31:0] model_fn(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_res  = '0;
    end else if (flush) begin
      m_left = 0;
      m_done = 1'b0;
    end else begin
      m_acc = in_valid && ((m_left == 0 && !m_done) || (m_done && out_ready));
      if (m_done && out_ready) m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end
      if (m_acc) begin
        m_res  = model_fn(op, rs1, rs2);
        m_left = NSL;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en && rst_n) begin
      chk("cmp_in_ready", 32'(in_ready),
          32'(!flush && ((m_left == 0 && !m_done) || (m_done && out_ready))));
      chk("cmp_out_valid", 32'(out_valid), 32'(m_done));
      chk("cmp_busy", 32'(busy), 32'(m_left > 0 || m_done));
      if (m_done) chk("cmp_rd", rd, m_res);
`ifdef LU_ZERO_FLAG_EN
      if (m_done) chk("cmp_zero", 32'(zero), 32'(m_res == '0));
`endif
    end
  end

  task automatic wait_valid(input string nm, input logic [31:0] exp);
    int n;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      #1;
      if (out_valid) break;
    end
    chk({nm, "_latency"}, 32'(n), 32'(NSL));
    chk({nm, "_rd"}, rd, exp);
  endtask

  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    @(posedge clk);
    #2;
    op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0; rs1 = $urandom; rs2 = $urandom; op = 2'($urandom);
    wait_valid(nm, exp);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 2'd0; rs1 = '0; rs2 = '0;

    chk("pin_or",  model_fn(2'd1, 32'hF0F0_0000, 32'h0F0F_00FF), 32'hFFFF_00FF);
    chk("pin_and", model_fn(2'd0, 32'hAAAA_5555, 32'hFFFF_0000), 32'hAAAA_0000);
    chk("pin_xor", model_fn(2'd2, 32'hAAAA_5555, 32'hFFFF_0000), 32'h5555_5555);
    chk("pin_nor", model_fn(2'd3, 32'hAAAA_5555, 32'hFFFF_0000), 32'h0000_AAAA);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_rd", rd, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    #1;
    rst_n = 1'b1;
    check_en = 1'b1;
    out_ready = 1'b1;

    run_op("or",   LU_OR,  32'hF0F0_0000, 32'h0F0F_00FF, 32'hFFFF_00FF);
    run_op("and",  LU_AND, 32'hAAAA_5555, 32'hFFFF_0000, 32'hAAAA_0000);
    run_op("xor",  LU_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
    run_op("nor",  LU_NOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h0000_AAAA);
    run_op("zand", LU_AND, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_0000);
`ifdef LU_ZERO_FLAG_EN
    chk("zero_flag", 32'(zero), 32'd1);
`endif

    // Backpressure with a second op waiting, then drain and accept in the same edge.
    @(posedge clk);
    #2;
    out_ready = 1'b0; op = LU_XOR; rs1 = 32'h1234_5678; rs2 = 32'h0F0F_0F0F; in_valid = 1'b1;
    @(posedge clk);
    #2;
    op = LU_OR; rs1 = 32'hA5A5_0000; rs2 = 32'h0000_5A5A;
    wait_valid("bp", 32'h1D3B_5977);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_rd", rd, 32'h1D3B_5977);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    #1;
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    wait_valid("b2b", 32'hA5A5_5A5A);

    // Flush while slice 2 is being written; a same-cycle request must be refused.
    @(posedge clk);
    #2;
    op = LU_AND; rs1 = 32'hFFFF_FFFF; rs2 = 32'h1357_2468; in_valid = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    flush = 1'b1; in_valid = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_rd", rd, 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_valid", 32'(seen), 32'd0);
    run_op("post_flush", LU_NOR, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF);

    // Asynchronous reset in the middle of an operation.
    @(posedge clk);
    #2;
    op = LU_OR; rs1 = 32'h0000_FFFF; rs2 = 32'h00FF_0000; in_valid = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_rd", rd, 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    run_op("post_rst", LU_XOR, 32'hFFFF_FFFF, 32'h0F0F_F0F0, 32'hF0F0_0F0F);

    // Random traffic checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      in_valid  = ($urandom_range(9) < 7);
      out_ready = ($urandom_range(9) < 6);
      flush     = ($urandom_range(39) == 0);
      op        = 2'($urandom);
      rs1       = $urandom;
      rs2       = ($urandom_range(7) == 0) ? ~rs1 : $urandom;
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
